// File: rtl/neuron_grid_cfg_scheduler.sv
// Arbitrates one neuron grid between 32-bit config beats and timestep ticks.
// Optional status outputs are enabled with `define CFG_SCHED_STATUS_EN.
module neuron_grid_cfg_scheduler #(
    parameter int unsigned PARAM_W = 368,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned BEATS   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               cfg_sel,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [31:0]        cfg_data,
    input  logic               tick_in,
    input  logic               grid_done,
    output logic               tick_out,
    output logic               param_wen,
    output logic [ADDR_W-1:0]  param_address,
    output logic [PARAM_W-1:0] param_data_in,
    output logic               neuron_inst_wen,
    output logic [ADDR_W-1:0]  neuron_inst_address,
    output logic [1:0]         neuron_inst_data_in,
    output logic               busy,
    output logic               cfg_error
`ifdef CFG_SCHED_STATUS_EN
    ,
    output logic [15:0]        param_commit_cnt,
    output logic [15:0]        tick_defer_cnt,
    output logic               overrun
`endif
);

    // Beats 0..BEATS-2 fill the low shift register; the final beat supplies the top slice.
    localparam int unsigned LowW = 32 * (BEATS - 1);
    localparam int unsigned TopW = PARAM_W - LowW;
    localparam int unsigned CntW = $clog2(BEATS + 1);
    localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StAssemble, StCommit, StRun} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]   cnt_q;
    logic [LowW-1:0]   low_q;
    logic [TopW-1:0]   top_q;
    logic [ADDR_W-1:0] addr_q;
    logic              tick_pending_q;
    logic              tick_out_q;
    logic              inst_wen_q;
    logic [ADDR_W-1:0] inst_addr_q;
    logic [1:0]        inst_data_q;
    logic              cfg_error_q;

    logic in_idle, in_asm, beat_acc, tick_go, inst_acc, burst_start;
    logic asm_acc, addr_bad, last_beat;

    assign in_idle     = (state_q == StIdle);
    assign in_asm      = (state_q == StAssemble);
    assign beat_acc    = cfg_valid & cfg_ready;
    assign tick_go     = in_idle & (tick_in | tick_pending_q);
    assign inst_acc    = in_idle & beat_acc & cfg_sel;
    assign burst_start = in_idle & beat_acc & ~cfg_sel;
    assign asm_acc     = in_asm & beat_acc;
    assign addr_bad    = asm_acc & (cfg_addr != addr_q);
    assign last_beat   = asm_acc & ~addr_bad & (cnt_q == LastBeat);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (tick_go) begin
                    state_d = StRun;
                end else if (burst_start) begin
                    state_d = StAssemble;
                end
            end
            StAssemble: begin
                if (addr_bad) begin
                    state_d = StIdle;
                end else if (last_beat) begin
                    state_d = StCommit;
                end
            end
            StCommit: state_d = StIdle;
            StRun: begin
                if (grid_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // An instruction beat during a burst is back-pressured rather than dropped.
    always_comb begin
        cfg_ready = 1'b0;
        case (state_q)
            StIdle:     cfg_ready = ~(tick_in | tick_pending_q);
            StAssemble: cfg_ready = ~cfg_sel;
            default:    cfg_ready = 1'b0;
        endcase
        param_wen = (state_q == StCommit);
        busy      = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            low_q          <= '0;
            top_q          <= '0;
            addr_q         <= '0;
            tick_pending_q <= 1'b0;
            tick_out_q     <= 1'b0;
            inst_wen_q     <= 1'b0;
            inst_addr_q    <= '0;
            inst_data_q    <= '0;
            cfg_error_q    <= 1'b0;
        end else begin
            tick_out_q <= tick_go;
            inst_wen_q <= inst_acc;
            if (inst_acc) begin
                inst_addr_q <= cfg_addr;
                inst_data_q <= cfg_data[1:0];
            end
            if (tick_go) begin
                tick_pending_q <= 1'b0;
            end else if (tick_in && !in_idle) begin
                tick_pending_q <= 1'b1;
            end
            if (addr_bad) begin
                cfg_error_q <= 1'b1;
            end
            if (burst_start) begin
                addr_q <= cfg_addr;
                low_q  <= {cfg_data, low_q[LowW-1:32]};
                cnt_q  <= CntW'(1);
            end else if (asm_acc) begin
                if (addr_bad) begin
                    cnt_q <= '0;
                end else if (last_beat) begin
                    top_q <= cfg_data[TopW-1:0];
                    cnt_q <= '0;
                end else begin
                    low_q <= {cfg_data, low_q[LowW-1:32]};
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
        end
    end

    assign tick_out            = tick_out_q;
    assign param_address       = addr_q;
    assign param_data_in       = {top_q, low_q};
    assign neuron_inst_wen     = inst_wen_q;
    assign neuron_inst_address = inst_addr_q;
    assign neuron_inst_data_in = inst_data_q;
    assign cfg_error           = cfg_error_q;

`ifdef CFG_SCHED_STATUS_EN
    logic [15:0] commit_cnt_q, defer_cnt_q;
    logic        overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_cnt_q <= '0;
            defer_cnt_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            if (param_wen && commit_cnt_q != 16'hFFFF) begin
                commit_cnt_q <= commit_cnt_q + 16'd1;
            end
            // Only the tick that raises tick_pending counts; merged ticks do not.
            if (tick_in && !in_idle && !tick_pending_q && defer_cnt_q != 16'hFFFF) begin
                defer_cnt_q <= defer_cnt_q + 16'd1;
            end
            if (tick_in && state_q == StRun) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign param_commit_cnt = commit_cnt_q;
    assign tick_defer_cnt   = defer_cnt_q;
    assign overrun          = overrun_q;
`endif

endmodule

// File: tb/tb_neuron_grid_cfg_scheduler.sv
// Directed bench for neuron_grid_cfg_scheduler with a strobe scoreboard.
module tb_neuron_grid_cfg_scheduler;

    localparam logic [1:0] KParam = 2'd0;
    localparam logic [1:0] KInst  = 2'd1;
    localparam logic [1:0] KTick  = 2'd2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic         cfg_sel = 1'b0;
    logic [7:0]   cfg_addr = '0;
    logic [31:0]  cfg_data = '0;
    logic         tick_in = 1'b0;
    logic         grid_done = 1'b0;
    logic         tick_out;
    logic         param_wen;
    logic [7:0]   param_address;
    logic [367:0] param_data_in;
    logic         neuron_inst_wen;
    logic [7:0]   neuron_inst_address;
    logic [1:0]   neuron_inst_data_in;
    logic         busy;
    logic         cfg_error;
`ifdef CFG_SCHED_STATUS_EN
    logic [15:0]  param_commit_cnt;
    logic [15:0]  tick_defer_cnt;
    logic         overrun;
`endif

    neuron_grid_cfg_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_sel             (cfg_sel),
        .cfg_addr            (cfg_addr),
        .cfg_data            (cfg_data),
        .tick_in             (tick_in),
        .grid_done           (grid_done),
        .tick_out            (tick_out),
        .param_wen           (param_wen),
        .param_address       (param_address),
        .param_data_in       (param_data_in),
        .neuron_inst_wen     (neuron_inst_wen),
        .neuron_inst_address (neuron_inst_address),
        .neuron_inst_data_in (neuron_inst_data_in),
        .busy                (busy),
        .cfg_error           (cfg_error)
`ifdef CFG_SCHED_STATUS_EN
        ,
        .param_commit_cnt    (param_commit_cnt),
        .tick_defer_cnt      (tick_defer_cnt),
        .overrun             (overrun)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   kind;
        logic [7:0]   addr;
        logic [367:0] data;
    } ev_t;

    ev_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [367:0] obs, input logic [367:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic [1:0] kind, input logic [7:0] addr,
                                 input logic [367:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endfunction

    function automatic logic [367:0] exp_word(input logic [31:0] base);
        logic [383:0] t;
        t = '0;
        for (int k = 0; k < 12; k++) t[32*k +: 32] = base + 32'(k);
        return t[367:0];
    endfunction

    // Every write/tick strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && (param_wen || neuron_inst_wen || tick_out)) begin
            ev_t         e;
            logic [1:0]  k_obs;
            logic [7:0]  a_obs;
            logic [367:0] d_obs;
            chk("strobe_onehot", 368'($countones({param_wen, neuron_inst_wen, tick_out})), 368'd1);
            k_obs = param_wen ? KParam : (neuron_inst_wen ? KInst : KTick);
            a_obs = param_wen ? param_address : (neuron_inst_wen ? neuron_inst_address : 8'd0);
            d_obs = param_wen ? param_data_in :
                    (neuron_inst_wen ? 368'(neuron_inst_data_in) : 368'd0);
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_strobe: observed kind %0d, expected no strobe", k_obs);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_kind", 368'(k_obs), 368'(e.kind));
                chk("sb_addr", 368'(a_obs), 368'(e.addr));
                chk("sb_data", d_obs, e.data);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic sel, input logic [7:0] addr, input logic [31:0] data);
        bit done;
        bit rdy;
        done = 0;
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = addr;
        cfg_data  = data;
        for (int i = 0; i < 50; i++) begin
            #1;
            rdy = cfg_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1;
                break;
            end
        end
        cfg_valid = 1'b0;
        n_vec++;
        assert (done) else begin
            n_err++;
            $error("FAIL beat_timeout: observed not accepted, expected accepted in 50 cycles");
        end
    endtask

    task automatic burst(input logic [7:0] addr, input logic [31:0] base, input int tick_at);
        for (int k = 0; k < 12; k++) begin
            tick_in = (k == tick_at);
            send_beat(1'b0, addr, base + 32'(k));
            tick_in = 1'b0;
        end
        push(KParam, addr, exp_word(base));
    endtask

    initial begin
        logic [31:0] rbase;

        // Reset state
        step(3);
        reset = 1'b0;
        chk("rst_cfg_ready", 368'(cfg_ready), 368'd1);
        chk("rst_busy", 368'(busy), 368'd0);
        chk("rst_strobes", 368'({param_wen, neuron_inst_wen, tick_out}), 368'd0);
        chk("rst_cfg_error", 368'(cfg_error), 368'd0);

        // Basic burst, data = beat index
        burst(8'h05, 32'd0, -1);
        chk("t1_param_wen", 368'(param_wen), 368'd1);
        chk("t1_addr", 368'(param_address), 368'h05);
        chk("t1_beat0", 368'(param_data_in[31:0]), 368'd0);
        chk("t1_beat10", 368'(param_data_in[351:320]), 368'd10);
        chk("t1_beat11", 368'(param_data_in[367:352]), 368'h000B);
        chk("t1_commit_ready", 368'(cfg_ready), 368'd0);
        step(1);

        // Back-to-back instruction writes
        push(KInst, 8'h10, 368'd2);
        send_beat(1'b1, 8'h10, 32'd2);
        push(KInst, 8'h11, 368'd1);
        chk("t2_wen0", 368'(neuron_inst_wen), 368'd1);
        send_beat(1'b1, 8'h11, 32'hFFFF_FFF1);
        chk("t2_wen1", 368'(neuron_inst_wen), 368'd1);
        chk("t2_addr1", 368'(neuron_inst_address), 368'h11);
        step(1);
        chk("t2_idle_quiet", 368'(neuron_inst_wen), 368'd0);

        // Tick during a burst is deferred past the commit
        burst(8'h05, 32'hA0, 6);
        push(KTick, 8'h00, 368'd0);
        chk("t3_commit", 368'(param_wen), 368'd1);
        chk("t3_no_tick_commit", 368'(tick_out), 368'd0);
        step(1);
        chk("t3_no_tick_idle", 368'(tick_out), 368'd0);
        chk("t3_ready_pending", 368'(cfg_ready), 368'd0);
        step(1);
        chk("t3_tick", 368'(tick_out), 368'd1);
        chk("t3_run_ready", 368'(cfg_ready), 368'd0);
        step(2);
        chk("t3_run_busy", 368'(busy), 368'd1);
        chk("t3_run_ready2", 368'(cfg_ready), 368'd0);
        grid_done = 1'b1;
        step(1);
        grid_done = 1'b0;
        chk("t3_idle_ready", 368'(cfg_ready), 368'd1);
        chk("t3_idle_busy", 368'(busy), 368'd0);

        // Address change inside a burst is discarded and flagged
        for (int k = 0; k < 4; k++) send_beat(1'b0, (k == 3) ? 8'h06 : 8'h05, 32'(k));
        chk("t4_error", 368'(cfg_error), 368'd1);
        chk("t4_busy", 368'(busy), 368'd0);
        chk("t4_no_wen", 368'(param_wen), 368'd0);
        rbase = $urandom;
        burst(8'h05, rbase, -1);
        chk("t4_recover_wen", 368'(param_wen), 368'd1);
        chk("t4_error_sticky", 368'(cfg_error), 368'd1);
        step(1);

        // grid_done outside RUN is ignored
        grid_done = 1'b1;
        step(1);
        grid_done = 1'b0;
        chk("t5_done_ignored", 368'(busy), 368'd0);

        // Overrun: tick during RUN re-fires after grid_done
        tick_in = 1'b1;
        push(KTick, 8'h00, 368'd0);
        step(1);
        tick_in = 1'b0;
        chk("t6_tick1", 368'(tick_out), 368'd1);
        tick_in = 1'b1;
        push(KTick, 8'h00, 368'd0);
        step(1);
        tick_in = 1'b0;
        step(1);
        grid_done = 1'b1;
        step(1);
        grid_done = 1'b0;
        chk("t6_idle_no_tick", 368'(tick_out), 368'd0);
        chk("t6_idle_busy", 368'(busy), 368'd0);
        step(1);
        chk("t6_tick2", 368'(tick_out), 368'd1);
        grid_done = 1'b1;
        step(1);
        grid_done = 1'b0;
`ifdef CFG_SCHED_STATUS_EN
        chk("t6_overrun", 368'(overrun), 368'd1);
        chk("t6_defer_cnt", 368'(tick_defer_cnt), 368'd2);
        chk("t6_commit_cnt", 368'(param_commit_cnt), 368'd3);
`endif

        // Tick wins over an instruction beat in the same cycle
        tick_in   = 1'b1;
        cfg_valid = 1'b1;
        cfg_sel   = 1'b1;
        cfg_addr  = 8'h20;
        cfg_data  = 32'd3;
        push(KTick, 8'h00, 368'd0);
        push(KInst, 8'h20, 368'd3);
        #1;
        chk("t7_ready_low", 368'(cfg_ready), 368'd0);
        step(1);
        tick_in = 1'b0;
        chk("t7_tick", 368'(tick_out), 368'd1);
        chk("t7_no_inst", 368'(neuron_inst_wen), 368'd0);
        step(3);
        chk("t7_held", 368'(cfg_ready), 368'd0);
        grid_done = 1'b1;
        step(1);
        grid_done = 1'b0;
        chk("t7_ready_back", 368'(cfg_ready), 368'd1);
        step(1);
        cfg_valid = 1'b0;
        chk("t7_inst_wen", 368'(neuron_inst_wen), 368'd1);
        chk("t7_inst_data", 368'(neuron_inst_data_in), 368'd3);

        // Reset mid-burst drops the partial word and clears the sticky error
        for (int k = 0; k < 5; k++) send_beat(1'b0, 8'h09, 32'h55 + 32'(k));
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        chk("t8_busy", 368'(busy), 368'd0);
        chk("t8_error_clr", 368'(cfg_error), 368'd0);
        chk("t8_no_wen", 368'(param_wen), 368'd0);
        chk("t8_data_clr", param_data_in, 368'd0);
        burst(8'h0A, 32'h1234_0000, -1);
        step(3);
        chk("sb_drained", 368'(sb.size()), 368'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish before 200us");
        $fatal(1, "timeout");
    end

endmodule
